// File: rtl/clock_set_ctrl_pkg.sv
// Shared types and constants for the DigitalClock mode/set controller.
package clock_pkg;

  typedef enum logic [2:0] {
    RUN,
    SET_HH,
    SET_MM,
    SET_SS,
    ALM_HH,
    ALM_MM
  } ctrl_state_e;

  // Decoded key after priority resolution; only one key is acted on per cycle.
  typedef enum logic [2:0] {
    KEY_NONE,
    KEY_MODE,
    KEY_NEXT,
    KEY_INC,
    KEY_DEC,
    KEY_ALM_EDIT,
    KEY_ALM_TOG
  } key_e;

  localparam int K_MODE     = 0;
  localparam int K_NEXT     = 1;
  localparam int K_INC      = 2;
  localparam int K_DEC      = 3;
  localparam int K_ALM_TOG  = 4;
  localparam int K_ALM_EDIT = 5;

  localparam logic [4:0] HH_MAX = 5'd23;
  localparam logic [5:0] MS_MAX = 6'd59;

  localparam logic [7:0] MASK_HH = 8'b0000_0011;
  localparam logic [7:0] MASK_MM = 8'b0001_1000;
  localparam logic [7:0] MASK_SS = 8'b1100_0000;

  function automatic key_e pick_key(input logic [5:0] k);
    if (k[K_MODE])          return KEY_MODE;
    else if (k[K_NEXT])     return KEY_NEXT;
    else if (k[K_INC])      return KEY_INC;
    else if (k[K_DEC])      return KEY_DEC;
    else if (k[K_ALM_EDIT]) return KEY_ALM_EDIT;
    else if (k[K_ALM_TOG])  return KEY_ALM_TOG;
    else                    return KEY_NONE;
  endfunction

  function automatic logic is_set(input ctrl_state_e s);
    return (s == SET_HH) || (s == SET_MM) || (s == SET_SS);
  endfunction

  function automatic logic is_alm(input ctrl_state_e s);
    return (s == ALM_HH) || (s == ALM_MM);
  endfunction

  function automatic logic [7:0] field_mask(input ctrl_state_e s);
    case (s)
      SET_HH, ALM_HH: return MASK_HH;
      SET_MM, ALM_MM: return MASK_MM;
      SET_SS:         return MASK_SS;
      default:        return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/clock_set_ctrl_if.sv
// Key/tick/time inputs and control/display outputs of the mode/set controller.
interface clock_set_ctrl_if;
  logic       tick_1hz;
  logic [5:0] key_pulse;
  logic [4:0] cur_hh;
  logic [5:0] cur_mm;
  logic [5:0] cur_ss;
  logic       run_en;
  logic       ld_en;
  logic [4:0] ld_hh;
  logic [5:0] ld_mm;
  logic [5:0] ld_ss;
  logic [4:0] disp_hh;
  logic [5:0] disp_mm;
  logic [5:0] disp_ss;
  logic [7:0] blink_mask;
  logic [3:0] led;
  logic       alarm_fire;

  modport master (
    output tick_1hz, key_pulse, cur_hh, cur_mm, cur_ss,
    input  run_en, ld_en, ld_hh, ld_mm, ld_ss, disp_hh, disp_mm, disp_ss,
           blink_mask, led, alarm_fire
  );

  modport slave (
    input  tick_1hz, key_pulse, cur_hh, cur_mm, cur_ss,
    output run_en, ld_en, ld_hh, ld_mm, ld_ss, disp_hh, disp_mm, disp_ss,
           blink_mask, led, alarm_fire
  );
endinterface

// File: rtl/clock_set_ctrl_field_adj.sv
// Wrapping increment/decrement of one time field (0..max_val).
module field_adj #(
  parameter int W = 6
) (
  input  logic [W-1:0] value,
  input  logic [W-1:0] max_val,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] result
);
  // NOTE: result gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    result = value;
    if (inc)      result = (value == max_val) ? '0 : value + 1'b1;
    else if (dec) result = (value == '0) ? max_val : value - 1'b1;
  end
endmodule

// File: rtl/clock_set_ctrl.sv
// Mode/set controller: run, time-edit and alarm-edit sequencing plus alarm and blink.
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int TIMEOUT_S = 30,
  parameter int ALARM_S   = 60
) (
  input logic             clk,
  input logic             rst,
  clock_set_ctrl_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT_S + 1);
  localparam int AW = $clog2(ALARM_S + 1);

  ctrl_state_e   state, nxt_state;
  logic [4:0]    edit_hh, nxt_edit_hh, alarm_hh, nxt_alarm_hh, adj_hh;
  logic [5:0]    edit_mm, nxt_edit_mm, alarm_mm, nxt_alarm_mm, adj_mm;
  logic [5:0]    edit_ss, nxt_edit_ss, adj_ss;
  logic          armed, nxt_armed, fire, nxt_fire, phase, nxt_phase, do_load;
  logic [TW-1:0] to_cnt, nxt_to;
  logic [AW-1:0] al_cnt, nxt_al;
  key_e          key;
  logic          any_key, alarm_match;

  assign key         = pick_key(bus.key_pulse);
  assign any_key     = |bus.key_pulse;
  assign alarm_match = (bus.cur_hh == alarm_hh) && (bus.cur_mm == alarm_mm) && (bus.cur_ss == 6'd0);

  field_adj #(.W(5)) u_adj_hh (
    .value(edit_hh), .max_val(HH_MAX),
    .inc(key == KEY_INC && (state == SET_HH || state == ALM_HH)),
    .dec(key == KEY_DEC && (state == SET_HH || state == ALM_HH)),
    .result(adj_hh)
  );
  field_adj #(.W(6)) u_adj_mm (
    .value(edit_mm), .max_val(MS_MAX),
    .inc(key == KEY_INC && (state == SET_MM || state == ALM_MM)),
    .dec(key == KEY_DEC && (state == SET_MM || state == ALM_MM)),
    .result(adj_mm)
  );
  field_adj #(.W(6)) u_adj_ss (
    .value(edit_ss), .max_val(MS_MAX),
    .inc(key == KEY_INC && state == SET_SS),
    .dec(key == KEY_DEC && state == SET_SS),
    .result(adj_ss)
  );

  always_comb begin
    nxt_state    = state;
    nxt_edit_hh  = edit_hh;
    nxt_edit_mm  = edit_mm;
    nxt_edit_ss  = edit_ss;
    nxt_alarm_hh = alarm_hh;
    nxt_alarm_mm = alarm_mm;
    nxt_armed    = armed;
    nxt_fire     = fire;
    nxt_to       = to_cnt;
    nxt_al       = al_cnt;
    nxt_phase    = phase;
    do_load      = 1'b0;

    // A key while the alarm rings only silences it; ALM_TOG also disarms.
    if (fire && any_key) begin
      nxt_fire = 1'b0;
      if (key == KEY_ALM_TOG) nxt_armed = 1'b0;
    end else begin
      case (state)
        RUN: begin
          case (key)
            KEY_MODE: begin
              nxt_state   = SET_HH;
              nxt_edit_hh = bus.cur_hh;
              nxt_edit_mm = bus.cur_mm;
              nxt_edit_ss = bus.cur_ss;
            end
            KEY_ALM_EDIT: begin
              nxt_state   = ALM_HH;
              nxt_edit_hh = alarm_hh;
              nxt_edit_mm = alarm_mm;
              nxt_edit_ss = 6'd0;
            end
            KEY_ALM_TOG: nxt_armed = ~armed;
            default: ;
          endcase
        end
        default: begin
          case (key)
            KEY_MODE: begin
              nxt_state = RUN;
              if (is_set(state)) begin
                do_load = 1'b1;
              end else begin
                nxt_alarm_hh = edit_hh;
                nxt_alarm_mm = edit_mm;
              end
            end
            KEY_NEXT: begin
              case (state)
                SET_HH:  nxt_state = SET_MM;
                SET_MM:  nxt_state = SET_SS;
                SET_SS:  nxt_state = SET_HH;
                ALM_HH:  nxt_state = ALM_MM;
                default: nxt_state = ALM_HH;
              endcase
            end
            KEY_INC, KEY_DEC: begin
              nxt_edit_hh = adj_hh;
              nxt_edit_mm = adj_mm;
              nxt_edit_ss = adj_ss;
            end
            default: ;
          endcase
        end
      endcase
    end

    // Edit inactivity timeout; a key and a tick in the same cycle restart at one.
    if (nxt_state == RUN || state == RUN) begin
      nxt_to = '0;
    end else if (any_key) begin
      nxt_to = bus.tick_1hz ? TW'(1) : '0;
    end else if (bus.tick_1hz) begin
      if (to_cnt == TW'(TIMEOUT_S - 1)) begin
        nxt_state = RUN;
        nxt_to    = '0;
      end else begin
        nxt_to = to_cnt + 1'b1;
      end
    end

    if (fire && nxt_fire) begin
      if (bus.tick_1hz) begin
        if (al_cnt == AW'(ALARM_S - 1)) nxt_fire = 1'b0;
        else                            nxt_al   = al_cnt + 1'b1;
      end
    end else if (!fire && state == RUN && nxt_state == RUN && nxt_armed &&
                 bus.tick_1hz && alarm_match) begin
      nxt_fire = 1'b1;
    end
    if (!nxt_fire) nxt_al = '0;

    if (nxt_state == RUN)                 nxt_phase = 1'b0;
    else if (bus.tick_1hz && state != RUN) nxt_phase = ~phase;
  end

  assign bus.alarm_fire = fire;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= RUN;
      edit_hh        <= '0;
      edit_mm        <= '0;
      edit_ss        <= '0;
      alarm_hh       <= '0;
      alarm_mm       <= '0;
      armed          <= 1'b0;
      fire           <= 1'b0;
      phase          <= 1'b0;
      to_cnt         <= '0;
      al_cnt         <= '0;
      bus.run_en     <= 1'b1;
      bus.ld_en      <= 1'b0;
      bus.ld_hh      <= '0;
      bus.ld_mm      <= '0;
      bus.ld_ss      <= '0;
      bus.disp_hh    <= bus.cur_hh;
      bus.disp_mm    <= bus.cur_mm;
      bus.disp_ss    <= bus.cur_ss;
      bus.blink_mask <= '0;
      bus.led        <= '0;
    end else begin
      state      <= nxt_state;
      edit_hh    <= nxt_edit_hh;
      edit_mm    <= nxt_edit_mm;
      edit_ss    <= nxt_edit_ss;
      alarm_hh   <= nxt_alarm_hh;
      alarm_mm   <= nxt_alarm_mm;
      armed      <= nxt_armed;
      fire       <= nxt_fire;
      phase      <= nxt_phase;
      to_cnt     <= nxt_to;
      al_cnt     <= nxt_al;
      bus.run_en <= ~is_set(nxt_state);
      bus.ld_en  <= do_load;
      if (do_load) begin
        bus.ld_hh <= edit_hh;
        bus.ld_mm <= edit_mm;
        bus.ld_ss <= edit_ss;
      end
      case (nxt_state)
        RUN: begin
          bus.disp_hh <= bus.cur_hh;
          bus.disp_mm <= bus.cur_mm;
          bus.disp_ss <= bus.cur_ss;
        end
        ALM_HH, ALM_MM: begin
          bus.disp_hh <= nxt_edit_hh;
          bus.disp_mm <= nxt_edit_mm;
          bus.disp_ss <= 6'd0;
        end
        default: begin
          bus.disp_hh <= nxt_edit_hh;
          bus.disp_mm <= nxt_edit_mm;
          bus.disp_ss <= nxt_edit_ss;
        end
      endcase
      bus.blink_mask <= nxt_phase ? field_mask(nxt_state) : 8'h00;
      bus.led        <= {nxt_fire, nxt_armed, is_alm(nxt_state), is_set(nxt_state)};
    end
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl: load/alarm events go through a scoreboard, levels via check().
module tb_clock_set_ctrl;
  import clock_pkg::*;

  localparam int TIMEOUT_S = 3;
  localparam int ALARM_S   = 4;

  localparam logic [5:0] B_MODE     = 6'b00_0001;
  localparam logic [5:0] B_NEXT     = 6'b00_0010;
  localparam logic [5:0] B_INC      = 6'b00_0100;
  localparam logic [5:0] B_DEC      = 6'b00_1000;
  localparam logic [5:0] B_ALM_TOG  = 6'b01_0000;
  localparam logic [5:0] B_ALM_EDIT = 6'b10_0000;

  typedef enum logic [1:0] {EV_LOAD, EV_FIRE_ON, EV_FIRE_OFF} ev_e;
  typedef struct {
    ev_e         kind;
    logic [16:0] data;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  ev_t  sb[$];
  logic prev_fire = 1'b0;

  clock_set_ctrl_if bus();

  clock_set_ctrl #(.TIMEOUT_S(TIMEOUT_S), .ALARM_S(ALARM_S)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input ev_e k, input logic [16:0] d);
    ev_t e;
    e.kind = k;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic sb_compare(input ev_e k, input logic [16:0] d);
    ev_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL sb_%s: got unexpected event data=%h, expected no event", k.name(), d);
    end else begin
      e = sb.pop_front();
      if (e.kind != k || e.data != d) begin
        n_bad++;
        $display("FAIL sb_event: got %s data=%h, expected %s data=%h", k.name(), d, e.kind.name(), e.data);
      end
    end
  endtask

  // Monitor: observes output events away from the active edge and retires scoreboard entries.
  always @(negedge clk) begin
    if (bus.ld_en === 1'b1) sb_compare(EV_LOAD, {bus.ld_hh, bus.ld_mm, bus.ld_ss});
    if (bus.alarm_fire === 1'b1 && !prev_fire) sb_compare(EV_FIRE_ON, 17'd0);
    if (bus.alarm_fire === 1'b0 && prev_fire)  sb_compare(EV_FIRE_OFF, 17'd0);
    prev_fire = (bus.alarm_fire === 1'b1);
  end

  task automatic press(input logic [5:0] k, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.key_pulse = k;
      @(negedge clk);
      bus.key_pulse = '0;
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.tick_1hz = 1'b1;
      @(negedge clk);
      bus.tick_1hz = 1'b0;
    end
  endtask

  task automatic set_cur(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
    bus.cur_hh = h;
    bus.cur_mm = m;
    bus.cur_ss = s;
  endtask

  initial begin
    bus.tick_1hz  = 1'b0;
    bus.key_pulse = '0;
    set_cur(5'd12, 6'd34, 6'd56);

    // T1 reset
    repeat (2) @(negedge clk);
    check("rst_run_en", 32'(bus.run_en), 32'd1);
    check("rst_ld_en", 32'(bus.ld_en), 32'd0);
    check("rst_alarm_fire", 32'(bus.alarm_fire), 32'd0);
    check("rst_led", 32'(bus.led), 32'h0);
    check("rst_blink", 32'(bus.blink_mask), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("run_disp", 32'({bus.disp_hh, bus.disp_mm, bus.disp_ss}), 32'({5'd12, 6'd34, 6'd56}));

    // T2 set time with wraps
    press(B_MODE, 1);
    check("t2_led_set", 32'(bus.led), 32'b0001);
    check("t2_run_en_edit", 32'(bus.run_en), 32'd0);
    press(B_INC, 12);
    check("t2_hh_wrap", 32'(bus.disp_hh), 32'd0);
    press(B_NEXT, 1);
    press(B_DEC, 35);
    check("t2_mm_wrap", 32'(bus.disp_mm), 32'd59);
    check("t2_hh_held", 32'(bus.disp_hh), 32'd0);
    check("t2_run_en_still0", 32'(bus.run_en), 32'd0);
    expect_ev(EV_LOAD, {5'd0, 6'd59, 6'd56});
    press(B_MODE, 1);
    check("t2_run_en_after", 32'(bus.run_en), 32'd1);
    check("t2_led_after", 32'(bus.led), 32'h0);

    // T3 timeout discards edit, no load
    press(B_MODE, 1);
    press(B_INC, 1);
    tick(1);
    check("t3_blink_hh", 32'(bus.blink_mask), 32'h03);
    tick(1);
    check("t3_still_edit", 32'(bus.led), 32'b0001);
    tick(1);
    check("t3_timeout_led", 32'(bus.led), 32'h0);
    check("t3_timeout_run_en", 32'(bus.run_en), 32'd1);
    check("t3_timeout_blink", 32'(bus.blink_mask), 32'h0);

    // T4 MODE beats INC in the same cycle
    press(B_MODE, 1);
    expect_ev(EV_LOAD, {5'd12, 6'd34, 6'd56});
    press(B_MODE | B_INC, 1);
    check("t4_back_to_run", 32'(bus.led), 32'h0);

    // T5 alarm edit, arm, fire, cancel and expiry
    press(B_ALM_EDIT, 1);
    check("t5_led_alm", 32'(bus.led), 32'b0010);
    check("t5_run_en_alm", 32'(bus.run_en), 32'd1);
    check("t5_disp_alm0", 32'({bus.disp_hh, bus.disp_mm, bus.disp_ss}), 32'd0);
    press(B_INC, 7);
    press(B_NEXT, 1);
    press(B_INC, 30);
    check("t5_disp_alm", 32'({bus.disp_hh, bus.disp_mm, bus.disp_ss}), 32'({5'd7, 6'd30, 6'd0}));
    press(B_MODE, 1);
    check("t5_no_ld_alm", 32'(bus.ld_en), 32'd0);
    press(B_ALM_TOG, 1);
    check("t5_armed", 32'(bus.led), 32'b0100);

    set_cur(5'd7, 6'd30, 6'd0);
    expect_ev(EV_FIRE_ON, 17'd0);
    tick(1);
    check("t5_fire", 32'(bus.alarm_fire), 32'd1);
    check("t5_fire_led", 32'(bus.led), 32'b1100);
    expect_ev(EV_FIRE_OFF, 17'd0);
    press(B_NEXT, 1);
    check("t5_key_cancel", 32'(bus.alarm_fire), 32'd0);
    check("t5_still_armed", 32'(bus.led), 32'b0100);

    expect_ev(EV_FIRE_ON, 17'd0);
    tick(1);
    set_cur(5'd7, 6'd30, 6'd1);
    tick(ALARM_S - 1);
    check("t5_fire_holds", 32'(bus.alarm_fire), 32'd1);
    expect_ev(EV_FIRE_OFF, 17'd0);
    tick(1);
    check("t5_fire_expired", 32'(bus.alarm_fire), 32'd0);

    set_cur(5'd7, 6'd30, 6'd0);
    expect_ev(EV_FIRE_ON, 17'd0);
    tick(1);
    set_cur(5'd7, 6'd30, 6'd1);
    expect_ev(EV_FIRE_OFF, 17'd0);
    press(B_ALM_TOG, 1);
    check("t5_tog_disarm", 32'(bus.led), 32'h0);

    // T6 blink in SET_MM, quiet in RUN
    press(B_MODE, 1);
    press(B_NEXT, 1);
    tick(1);
    check("t6_blink_on", 32'(bus.blink_mask), 32'h18);
    tick(1);
    check("t6_blink_off", 32'(bus.blink_mask), 32'h00);
    press(B_INC, 1);
    tick(1);
    check("t6_blink_on2", 32'(bus.blink_mask), 32'h18);
    expect_ev(EV_LOAD, {5'd7, 6'd31, 6'd1});
    press(B_MODE, 1);
    check("t6_run_blink", 32'(bus.blink_mask), 32'h00);
    tick(1);
    check("t6_run_blink_tick", 32'(bus.blink_mask), 32'h00);

    // Reset mid-edit loses the edit without a load
    press(B_MODE, 1);
    press(B_INC, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_led", 32'(bus.led), 32'h0);
    check("rst_mid_run_en", 32'(bus.run_en), 32'd1);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mid_disp", 32'({bus.disp_hh, bus.disp_mm, bus.disp_ss}), 32'({5'd7, 6'd30, 6'd1}));
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
